// File: rtl/irq_controller_pkg.sv
// Shared definitions for the exception/interrupt controller and the core's PC reset.
package irq_controller_pkg;

  // Bit positions in the one-hot cause register
  localparam int CAUSE_ERR  = 0;
  localparam int CAUSE_OVF  = 1;
  localparam int CAUSE_SRC0 = 2;

  localparam logic [31:0] VECTOR_DEF  = 32'h8000_0008;
  localparam logic [31:0] EPC_RST_DEF = 32'h8000_0000;

  typedef enum logic {
    USER    = 1'b0,
    HANDLER = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; one-hot grant plus any-request flag.
module irq_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Exception/interrupt controller for the single-cycle MIPS32 core: priority, mask, EPC/Cause.
// state   | meaning
// USER    | normal execution; exceptions and unmasked pending interrupts are taken
// HANDLER | handler running; only exceptions are recognised (double fault)
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NSRC    = 3,
  parameter logic [31:0] VECTOR  = VECTOR_DEF,
  parameter logic [31:0] EPC_RST = EPC_RST_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [31:0]     pc_i,
  input  logic            exc_err_i,
  input  logic            exc_ovf_i,
  input  logic [NSRC-1:0] irq_src_i,
  input  logic            mask_wr_i,
  input  logic [NSRC-1:0] mask_data_i,
  input  logic            eret_i,
  output logic            take_o,
  output logic [31:0]     vector_o,
  output logic [31:0]     epc_o,
  output logic [31:0]     cause_o,
  output logic [NSRC-1:0] pending_o,
  output logic [NSRC-1:0] mask_o,
  output logic            in_handler_o,
  output logic            fault_o
);

  localparam int NREQ = NSRC + 2;

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] src_prev_q;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     cause_q, cause_d;
  logic            fault_q, fault_d;

  logic [NSRC-1:0] irq_req;
  logic [NREQ-1:0] req, gnt;
  logic            req_valid;

  // Interrupts are invisible to the encoder while a handler runs
  assign irq_req = (state_q == USER) ? (pending_q & mask_q) : '0;

  always_comb begin
    req                     = '0;
    req[CAUSE_ERR]          = exc_err_i;
    req[CAUSE_OVF]          = exc_ovf_i;
    req[CAUSE_SRC0 +: NSRC] = irq_req;
  end

  irq_prio_enc #(.N(NREQ)) u_prio (
    .req_i   (req),
    .gnt_o   (gnt),
    .valid_o (req_valid)
  );

  assign take_o = req_valid & Rst;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    fault_d   = fault_q;
    case (state_q)
      USER: begin
        if (take_o) begin
          epc_d             = pc_i;
          cause_d           = '0;
          cause_d[NREQ-1:0] = gnt;
          pending_d         = pending_q & ~gnt[CAUSE_SRC0 +: NSRC];
          state_d           = HANDLER;
        end
      end
      HANDLER: begin
        if (take_o) fault_d = 1'b1;
        else if (eret_i) state_d = USER;
      end
      default: state_d = USER;
    endcase
    // A new edge on the same cycle as its take is kept as a fresh event
    pending_d = pending_d | (irq_src_i & ~src_prev_q);
    if (mask_wr_i) mask_d = mask_data_i;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= USER;
      pending_q  <= '0;
      mask_q     <= '1;
      src_prev_q <= '0;
      epc_q      <= EPC_RST;
      cause_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= irq_src_i;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      fault_q    <= fault_d;
    end
  end

  assign vector_o     = VECTOR;
  assign epc_o        = epc_q;
  assign cause_o      = cause_q;
  assign pending_o    = pending_q;
  assign mask_o       = mask_q;
  assign in_handler_o = (state_q == HANDLER);
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: per-cycle comparison against a rule-level model plus directed literals.
module tb_irq_controller;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        exc_err_i = 1'b0;
  logic        exc_ovf_i = 1'b0;
  logic [2:0]  irq_src_i = '0;
  logic        mask_wr_i = 1'b0;
  logic [2:0]  mask_data_i = '0;
  logic        eret_i = 1'b0;
  logic        take_o;
  logic [31:0] vector_o, epc_o, cause_o;
  logic [2:0]  pending_o, mask_o;
  logic        in_handler_o, fault_o;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .pc_i         (pc_i),
    .exc_err_i    (exc_err_i),
    .exc_ovf_i    (exc_ovf_i),
    .irq_src_i    (irq_src_i),
    .mask_wr_i    (mask_wr_i),
    .mask_data_i  (mask_data_i),
    .eret_i       (eret_i),
    .take_o       (take_o),
    .vector_o     (vector_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o),
    .pending_o    (pending_o),
    .mask_o       (mask_o),
    .in_handler_o (in_handler_o),
    .fault_o      (fault_o)
  );

  always #5 Clk = ~Clk;

  // Model state, expressed as the architectural rules
  logic [2:0]  m_pend = '0;
  logic [2:0]  m_mask = 3'b111;
  logic [2:0]  m_prev = '0;
  logic        m_inh = 1'b0;
  logic [31:0] m_epc = 32'h8000_0000;
  logic [31:0] m_cause = '0;
  logic        m_fault = 1'b0;

  // Winning source index (0 err, 1 ovf, 2+i src i) or -1 when nothing is taken
  function automatic int model_winner();
    if (exc_err_i) return 0;
    if (exc_ovf_i) return 1;
    if (!m_inh)
      for (int i = 0; i < 3; i++)
        if (m_pend[i] && m_mask[i]) return 2 + i;
    return -1;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_pend = '0; m_mask = 3'b111; m_prev = '0; m_inh = 1'b0;
      m_epc = 32'h8000_0000; m_cause = '0; m_fault = 1'b0;
    end else begin
      int w;
      logic [2:0] np;
      w  = model_winner();
      np = m_pend;
      if (w >= 0 && !m_inh) begin
        m_epc   = pc_i;
        m_cause = 32'd1 << w;
        if (w >= 2) np[w-2] = 1'b0;
        m_inh   = 1'b1;
      end else if (w >= 0) begin
        m_fault = 1'b1;
      end else if (eret_i && m_inh) begin
        m_inh = 1'b0;
      end
      for (int i = 0; i < 3; i++)
        if (irq_src_i[i] && !m_prev[i]) np[i] = 1'b1;
      m_pend = np;
      m_prev = irq_src_i;
      if (mask_wr_i) m_mask = mask_data_i;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        chk("cmp_take_rst", {31'b0, take_o}, 32'd0);
      end else begin
        chk("cmp_take", {31'b0, take_o}, {31'b0, model_winner() >= 0});
        chk("cmp_epc", epc_o, m_epc);
        chk("cmp_cause", cause_o, m_cause);
        chk("cmp_pending", {29'b0, pending_o}, {29'b0, m_pend});
        chk("cmp_mask", {29'b0, mask_o}, {29'b0, m_mask});
        chk("cmp_in_handler", {31'b0, in_handler_o}, {31'b0, m_inh});
        chk("cmp_fault", {31'b0, fault_o}, {31'b0, m_fault});
        chk("cmp_vector", vector_o, 32'h8000_0008);
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int ntake;
    fork
      compare_loop();
    join_none

    step(); step();
    Rst = 1'b1;
    step();
    chk("rst_epc", epc_o, 32'h8000_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_mask", {29'b0, mask_o}, 32'h7);
    chk("rst_pending", {29'b0, pending_o}, 32'h0);
    chk("rst_in_handler", {31'b0, in_handler_o}, 32'h0);

    // Test 1: rising src0 is taken the cycle after its edge
    pc_i = 32'h0000_0040; irq_src_i = 3'b001;
    step();
    chk("t1_take", {31'b0, take_o}, 32'd1);
    step();
    chk("t1_epc", epc_o, 32'h0000_0040);
    chk("t1_cause", cause_o, 32'h4);
    chk("t1_pending", {29'b0, pending_o}, 32'h0);
    chk("t1_in_handler", {31'b0, in_handler_o}, 32'd1);

    // Test 4: edge captured in HANDLER, taken one cycle after eret
    irq_src_i = 3'b000; step();
    irq_src_i = 3'b001; step();
    chk("t4_pending", {29'b0, pending_o}, 32'h1);
    chk("t4_take_hdl", {31'b0, take_o}, 32'd0);
    eret_i = 1'b1; #1;
    chk("t4_take_eret", {31'b0, take_o}, 32'd0);
    step(); eret_i = 1'b0; #1;
    chk("t4_take_after", {31'b0, take_o}, 32'd1);
    step();
    chk("t4_cause", cause_o, 32'h4);

    // Test 2: exceptions beat a pending interrupt, err beats ovf
    irq_src_i = 3'b010; step();
    chk("t2_pending_pre", {29'b0, pending_o}, 32'h2);
    eret_i = 1'b1; step(); eret_i = 1'b0;
    exc_err_i = 1'b1; exc_ovf_i = 1'b1; pc_i = 32'h0000_0100; #1;
    chk("t2_take", {31'b0, take_o}, 32'd1);
    step();
    chk("t2_cause", cause_o, 32'h1);
    chk("t2_pending", {29'b0, pending_o}, 32'h2);

    // Test 5: double fault keeps EPC/Cause and sets sticky fault
    exc_err_i = 1'b0; exc_ovf_i = 1'b1; pc_i = 32'h0000_0200; #1;
    chk("t5_take", {31'b0, take_o}, 32'd1);
    step();
    exc_ovf_i = 1'b0;
    chk("t5_fault", {31'b0, fault_o}, 32'd1);
    chk("t5_epc", epc_o, 32'h0000_0100);
    chk("t5_cause", cause_o, 32'h1);

    // Drain the leftover src1 request
    eret_i = 1'b1; step(); eret_i = 1'b0; step();
    chk("drain_cause", cause_o, 32'h8);
    irq_src_i = 3'b000;
    eret_i = 1'b1; step(); eret_i = 1'b0; step();

    // Test 3: masked sources stay pending; unmasking src2 takes it
    mask_wr_i = 1'b1; mask_data_i = 3'b000; step(); mask_wr_i = 1'b0;
    irq_src_i = 3'b111; step();
    chk("t3_pending", {29'b0, pending_o}, 32'h7);
    chk("t3_take_masked", {31'b0, take_o}, 32'd0);
    mask_wr_i = 1'b1; mask_data_i = 3'b100; #1;
    chk("t3_take_oldmask", {31'b0, take_o}, 32'd0);
    step(); mask_wr_i = 1'b0; #1;
    chk("t3_take", {31'b0, take_o}, 32'd1);
    step();
    chk("t3_cause", cause_o, 32'h10);
    chk("t3_pending_after", {29'b0, pending_o}, 32'h3);

    // Async reset mid-handler
    irq_src_i = 3'b000;
    #2 Rst = 1'b0; #1;
    chk("rst2_in_handler", {31'b0, in_handler_o}, 32'd0);
    chk("rst2_epc", epc_o, 32'h8000_0000);
    chk("rst2_mask", {29'b0, mask_o}, 32'h7);
    chk("rst2_fault", {31'b0, fault_o}, 32'd0);
    chk("rst2_take", {31'b0, take_o}, 32'd0);
    step();
    Rst = 1'b1;
    step();

    // Test 6: a held level produces exactly one take
    irq_src_i = 3'b010; ntake = 0;
    for (int c = 0; c < 10; c++) begin
      eret_i = (c == 4);
      step();
      if (take_o) ntake++;
    end
    eret_i = 1'b0;
    chk("t6_takes", ntake, 32'd1);
    chk("t6_cause", cause_o, 32'h8);
    chk("t6_in_handler", {31'b0, in_handler_o}, 32'd0);
    irq_src_i = 3'b000;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
